// File: rtl/seq_input_checker_if.sv
// seq_input_checker_if: player-side sequence checker bus (game FSM/ROM side is master)
interface seq_input_checker_if #(
  parameter int ADDR_W  = 4,
  parameter int NUM_BTN = 4
);
  logic               start;
  logic [ADDR_W-1:0]  nivel;
  logic [NUM_BTN-1:0] botoes;
  logic [NUM_BTN-1:0] esperado;
  logic [ADDR_W-1:0]  address;
  logic [1:0]         codigo;
  logic               acerto;
  logic               erro;
  logic               rodada_ok;
  logic               ocupado;
  logic               tempo_esgotado;
  modport master (
    output start, nivel, botoes, esperado,
    input  address, codigo, acerto, erro, rodada_ok, ocupado, tempo_esgotado
  );
  modport slave (
    input  start, nivel, botoes, esperado,
    output address, codigo, acerto, erro, rodada_ok, ocupado, tempo_esgotado
  );
endinterface

// File: rtl/seq_input_checker.sv
// seq_input_checker: walks ROM steps 0..nivel, checking one-hot button presses against the ROM colour.
// Optional idle-press timeout enabled by defining SEQ_TIMEOUT_EN.
module seq_input_checker #(
  parameter int ADDR_W         = 4,
  parameter int NUM_BTN        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  seq_input_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, CHECK, WAIT_RELEASE} state_t;
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  address_q, address_d, nivel_q, nivel_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [1:0]         codigo_q, codigo_d, enc;
  logic               acerto_q, acerto_d, erro_q, erro_d, rodada_q, rodada_d;
  logic               tempo_q, tempo_d, ocupado_q, ocupado_d;
  logic               none, multi, timeout;
  assign none  = bus.botoes == '0;
  assign multi = (bus.botoes & (bus.botoes - NUM_BTN'(1))) != '0;
  assign enc   = {bus.botoes[2] | bus.botoes[3], bus.botoes[1] | bus.botoes[3]};
`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout = state_q == WAIT_PRESS && none && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  // cleared on every entry to WAIT_PRESS, frozen everywhere else
  always_comb
    cnt_d = (state_d == WAIT_PRESS && state_q != WAIT_PRESS) ? '0 :
            (state_q == WAIT_PRESS && none) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    nivel_d   = nivel_q;
    press_d   = press_q;
    codigo_d  = codigo_q;
    acerto_d  = 1'b0;
    erro_d    = 1'b0;
    rodada_d  = 1'b0;
    tempo_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        nivel_d   = bus.nivel;
        address_d = '0;
        state_d   = WAIT_PRESS;
      end
      WAIT_PRESS: if (timeout || multi) begin
        erro_d    = 1'b1;
        tempo_d   = timeout;
        address_d = '0;
        state_d   = IDLE;
      end else if (!none) begin
        press_d  = bus.botoes;
        codigo_d = enc;
        state_d  = CHECK;
      end
      CHECK: if (press_q == bus.esperado) begin
        acerto_d = 1'b1;
        state_d  = WAIT_RELEASE;
      end else begin
        erro_d    = 1'b1;
        address_d = '0;
        state_d   = IDLE;
      end
      WAIT_RELEASE: if (none) begin
        rodada_d  = address_q == nivel_q;
        address_d = rodada_d ? '0 : address_q + ADDR_W'(1);
        state_d   = rodada_d ? IDLE : WAIT_PRESS;
      end
      default: state_d = IDLE;
    endcase
    ocupado_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      address_q <= '0;
      nivel_q   <= '0;
      press_q   <= '0;
      codigo_q  <= '0;
      acerto_q  <= 1'b0;
      erro_q    <= 1'b0;
      rodada_q  <= 1'b0;
      tempo_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      nivel_q   <= nivel_d;
      press_q   <= press_d;
      codigo_q  <= codigo_d;
      acerto_q  <= acerto_d;
      erro_q    <= erro_d;
      rodada_q  <= rodada_d;
      tempo_q   <= tempo_d;
      ocupado_q <= ocupado_d;
    end
  end
  assign bus.address        = address_q;
  assign bus.codigo         = codigo_q;
  assign bus.acerto         = acerto_q;
  assign bus.erro           = erro_q;
  assign bus.rodada_ok      = rodada_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.tempo_esgotado = tempo_q;
endmodule

// File: tb/tb_seq_input_checker.sv
// tb_seq_input_checker: scoreboard bench; expected pulses are queued by stimulus, popped by a monitor.
module tb_seq_input_checker;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  localparam int ACK = 0, ERR = 1, RND = 2;
  typedef struct {int kind; int code; int addr; int tempo; int cyc;} exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, chk = 0, errs = 0;
  logic [3:0] rom [16];
  int lvl, step;
  int last_code = 0;
  exp_t q[$];
  seq_input_checker_if #(.ADDR_W(4), .NUM_BTN(4)) bus();
  seq_input_checker #(.ADDR_W(4), .NUM_BTN(4), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.esperado = rom[bus.address];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int enc(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic expect_ev(input int k, input int code, input int addr, input int t, input int c);
    exp_t e;
    e = '{k, code, addr, t, c};
    q.push_back(e);
  endtask
  always @(negedge clk) if (!rst) begin
    if (int'(bus.acerto) + int'(bus.erro) + int'(bus.rodada_ok) > 1) check("pulse_exclusive", 1, 0);
    if (bus.tempo_esgotado && !bus.erro) check("tempo_without_erro", 1, 0);
    if (bus.acerto || bus.erro || bus.rodada_ok) begin
      if (q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", bus.acerto ? ACK : bus.erro ? ERR : RND, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        check("codigo", int'(bus.codigo), e.code);
        check("address", int'(bus.address), e.addr);
        check("tempo_esgotado", int'(bus.tempo_esgotado), e.tempo);
      end
    end
  end
  task automatic begin_round(input int n);
    lvl = n;
    step = 0;
    bus.nivel = 4'(n);
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  // a press is judged from the colour rules alone: multi-press, matching ROM colour, or mismatch
  task automatic press(input logic [3:0] v, input int hold, output bit ok);
    int c;
    c = cyc;
    bus.botoes = v;
    ok = 0;
    if ($countones(v) > 1) expect_ev(ERR, last_code, 0, 0, c + 1);
    else begin
      last_code = enc(v);
      ok = v == rom[step];
      expect_ev(ok ? ACK : ERR, last_code, ok ? step : 0, 0, c + 2);
    end
    repeat (hold) tick();
    bus.botoes = 0;
    if (ok) begin
      if (step == lvl) begin
        expect_ev(RND, last_code, 0, 0, cyc + 1);
        ok = 0;
      end
      step++;
    end
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    check({name, "_drained"}, q.size(), 0);
    check({name, "_ocupado"}, int'(bus.ocupado), 0);
    check({name, "_address"}, int'(bus.address), 0);
  endtask
  task automatic round(input string name, input int n, input int fstep, input logic [3:0] fval);
    bit ok;
    logic [3:0] v;
    ok = 1;
    begin_round(n);
    for (int s = 0; s <= n && ok; s++) begin
      v = (s == fstep && fval != 0) ? fval : rom[s];
      if (v == 0) v = 4'b0001;
      press(v, 2 + int'($urandom % 3), ok);
      repeat (1 + $urandom % 3) tick();
    end
    drain(name);
  endtask
  initial begin
    bit ok;
    bus.start = 0;
    bus.nivel = 0;
    bus.botoes = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001;
    repeat (3) tick();
    check("rst_address", int'(bus.address), 0);
    check("rst_codigo", int'(bus.codigo), 0);
    check("rst_ocupado", int'(bus.ocupado), 0);
    check("rst_pulses", int'({bus.acerto, bus.erro, bus.rodada_ok, bus.tempo_esgotado}), 0);
    rst = 0;
    tick();
    rom[0] = 4'b0001; rom[1] = 4'b1000; rom[2] = 4'b0100; rom[3] = 4'b1000;
    round("full_round", 3, -1, 0);
    check("full_round_codigo", int'(bus.codigo), 3);
    round("wrong_colour", 3, 1, 4'b0010);
    round("multi_press", 3, 0, 4'b0101);
    begin_round(1);
    press(4'b0001, 20, ok);
    check("held_address_before_release", int'(bus.address), 0);
    tick();
    check("held_address_after_release", int'(bus.address), 1);
    press(rom[1], 3, ok);
    tick();
    drain("held_button");
    begin_round(3);
    press(rom[0], 2, ok);
    tick();
    press(rom[1], 2, ok);
    repeat (2) tick();
    check("mid_address", int'(bus.address), 2);
    bus.nivel = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    check("start_ignored_address", int'(bus.address), 2);
    check("start_ignored_ocupado", int'(bus.ocupado), 1);
    rst = 1;
    tick();
    rst = 0;
    last_code = 0;
    check("mid_rst_outputs", int'({bus.address, bus.codigo, bus.acerto, bus.erro, bus.rodada_ok,
                                   bus.ocupado, bus.tempo_esgotado}), 0);
    round("after_rst", 0, -1, 0);
`ifdef SEQ_TIMEOUT_EN
    begin
      int c;
      c = cyc;
      bus.nivel = 0;
      bus.start = 1;
      tick();
      bus.start = 0;
      expect_ev(ERR, last_code, 0, 1, c + 1 + TO);
      repeat (TO + 3) tick();
      drain("timeout");
    end
`else
    begin_round(0);
    repeat (100) tick();
    check("no_timeout_ocupado", int'(bus.ocupado), 1);
    check("no_timeout_queue", q.size(), 0);
    rst = 1;
    tick();
    rst = 0;
    last_code = 0;
    tick();
`endif
    for (int r = 0; r < 25; r++) begin
      int n, fs;
      n = int'($urandom % 8);
      for (int i = 0; i < 16; i++) rom[i] = ($urandom % 10 == 0) ? 4'b0000 : 4'(1 << ($urandom % 4));
      fs = ($urandom % 3 == 0) ? -1 : int'($urandom % (n + 1));
      round("random_round", n, fs, 4'(1 + $urandom % 15));
    end
    check("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d expected pulses outstanding", q.size());
    $fatal(1, "watchdog");
  end
endmodule
